// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK bit slicer: default frame constants,
// sync FSM state encoding and the accumulator width helper.
package bpsk_pkg;

    localparam logic [7:0] SYNC_WORD_DEFAULT   = 8'hA5;
    localparam int         FRAME_BYTES_DEFAULT = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Accumulator width that cannot overflow over one full symbol.
    function automatic int acc_width(input int sample_width, input int samples_per_bit);
        return sample_width + $clog2(samples_per_bit);
    endfunction

endpackage

// File: rtl/bpsk_integrate_dump.sv
// Integrate-and-dump over one symbol period followed by a hard slicer.
// Emits one bit strobe per SAMPLES_PER_BIT accepted samples.
module bpsk_integrate_dump
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 12,
    parameter int SAMPLES_PER_BIT = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    output logic                           bit_out,
    output logic                           bit_valid
);

    localparam int ACC_W = acc_width(SAMPLE_WIDTH, SAMPLES_PER_BIT);
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_BIT - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;

    assign accept = en & sample_valid;
    assign sum    = acc + {{(ACC_W-SAMPLE_WIDTH){sample_in[SAMPLE_WIDTH-1]}}, sample_in};

    // Accumulate accepted samples; on the last sample of a symbol slice and dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (accept) begin
                if (cnt == LAST_CNT) begin
                    // Strictly positive integral slices to 1; zero slices to 0.
                    bit_out   <= ~sum[ACC_W-1] & (sum != '0);
                    bit_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bpsk_bit_slicer.sv
// BPSK bit slicer: integrate-and-dump, sync-word hunt and frame deserializer.
// Optional macro BPSK_PHASE_AMBIG_EN also accepts the inverted sync word,
// flips locked payload bits accordingly and adds the phase_inv output.
module bpsk_bit_slicer
    import bpsk_pkg::*;
#(
    parameter int         SAMPLE_WIDTH    = 12,
    parameter int         SAMPLES_PER_BIT = 256,
    parameter logic [7:0] SYNC_WORD       = SYNC_WORD_DEFAULT,
    parameter int         FRAME_BYTES     = FRAME_BYTES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    input  logic                           resync,
    output logic                           bit_out,
    output logic                           bit_valid,
    output logic [7:0]                     byte_out,
    output logic                           byte_valid,
    output logic                           locked
`ifdef BPSK_PHASE_AMBIG_EN
    ,
    output logic                           phase_inv
`endif
);

    localparam int BC_W = $clog2(FRAME_BYTES + 1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(FRAME_BYTES - 1);

    state_t          state;
    logic [7:0]      shreg;
    logic [2:0]      fill_cnt;
    logic [2:0]      bit_cnt;
    logic [BC_W-1:0] byte_cnt;
    logic            invert;
    logic [7:0]      hunt_shreg;
    logic [7:0]      lock_shreg;
    logic            match_true;
    logic            match_inv;

    bpsk_integrate_dump #(
        .SAMPLE_WIDTH    (SAMPLE_WIDTH),
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
    ) u_integrate_dump (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid)
    );

    // Hunting shifts raw bits; locked payload bits are corrected for phase.
    assign hunt_shreg = {shreg[6:0], bit_out};
    assign lock_shreg = {shreg[6:0], bit_out ^ invert};
    // A match needs a full window: seven bits already held plus this one.
    assign match_true = (fill_cnt == 3'd7) && (hunt_shreg == SYNC_WORD);
`ifdef BPSK_PHASE_AMBIG_EN
    assign match_inv  = (fill_cnt == 3'd7) && (hunt_shreg == ~SYNC_WORD);
    assign phase_inv  = invert;
`else
    assign match_inv  = 1'b0;
`endif

    // Sync hunt / payload deserializer, advancing once per sliced bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            locked     <= 1'b0;
            shreg      <= 8'h00;
            fill_cnt   <= 3'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            invert     <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (resync) begin
                // Symbol timing lives in the integrator and is left alone.
                state    <= HUNT;
                locked   <= 1'b0;
                shreg    <= 8'h00;
                fill_cnt <= 3'd0;
                bit_cnt  <= 3'd0;
                byte_cnt <= '0;
                invert   <= 1'b0;
            end else if (bit_valid) begin
                case (state)
                    HUNT: begin
                        shreg <= hunt_shreg;
                        if (fill_cnt != 3'd7) begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                        if (match_true || match_inv) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= '0;
                            invert   <= match_inv;
                        end
                    end
                    LOCKED: begin
                        shreg   <= lock_shreg;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_out   <= lock_shreg;
                            byte_valid <= 1'b1;
                            if (byte_cnt == LAST_BYTE) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                shreg    <= 8'h00;
                                fill_cnt <= 3'd0;
                                byte_cnt <= '0;
                                invert   <= 1'b0;
                            end else begin
                                byte_cnt <= byte_cnt + BC_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bpsk_bit_slicer.sv
// Self-checking bench for bpsk_bit_slicer (SAMPLES_PER_BIT=8, FRAME_BYTES=2).
// Expected bits/bytes are queued as stimulus is driven and popped by a monitor.
module tb_bpsk_bit_slicer;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [11:0] sample_in;
    logic               sample_valid;
    logic               resync;
    logic               bit_out;
    logic               bit_valid;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               locked;
`ifdef BPSK_PHASE_AMBIG_EN
    logic               phase_inv;
    localparam bit AMBIG = 1'b1;
`else
    localparam bit AMBIG = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit         exp_bits[$];
    logic [7:0] exp_bytes[$];

    bpsk_bit_slicer #(
        .SAMPLE_WIDTH    (12),
        .SAMPLES_PER_BIT (8),
        .SYNC_WORD       (8'hA5),
        .FRAME_BYTES     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .resync       (resync),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .locked       (locked)
`ifdef BPSK_PHASE_AMBIG_EN
        ,
        .phase_inv    (phase_inv)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bit_valid) begin
                if (exp_bits.size() == 0) check("unexpected_bit", 32'd1, 32'd0);
                else                      check("bit_out", {31'd0, bit_out}, {31'd0, exp_bits.pop_front()});
            end
            if (byte_valid) begin
                if (exp_bytes.size() == 0) check("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
                else                       check("byte_out", {24'd0, byte_out}, {24'd0, exp_bytes.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive(input logic signed [11:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_resync();
        idle(2);
        resync = 1'b1;
        tick();
        resync = 1'b0;
    endtask

    // One symbol of test-plan samples: 0:+100, 1:-100, 2:alternating (sum 0).
    task automatic send_level(input int mode);
        exp_bits.push_back(mode == 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("no_early_bit", {31'd0, bit_valid}, 32'd0);
            if (mode == 0)      drive(12'sd100);
            else if (mode == 1) drive(-12'sd100);
            else                drive((i % 2 == 0) ? 12'sd100 : -12'sd100);
        end
        check("bit_latency", {31'd0, bit_valid}, 32'd1);
    endtask

    task automatic send_bit(input bit b, input bit slow, input bit gap, input bit neg);
        logic signed [11:0] v;
        v = (b ^ neg) ? 12'sd500 : -12'sd500;
        exp_bits.push_back(b ^ neg);
        for (int i = 0; i < 8; i++) begin
            if (slow) idle(1);
            if (gap && i == 3) begin
                en           = 1'b0;
                sample_in    = v;
                sample_valid = 1'b1;
                repeat (5) begin
                    tick();
                    check("no_strobe_en_low", {30'd0, bit_valid, byte_valid}, 32'd0);
                end
                en = 1'b1;
            end
            drive(v);
        end
        check("bit_latency", {31'd0, bit_valid}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] by, input bit slow, input bit gap, input bit neg);
        for (int k = 7; k >= 0; k--) send_bit(by[k], slow, gap && (k == 4), neg);
    endtask

    // Preamble 0,1 then sync A5 and payload 3C, C3.
    task automatic send_stream(input bit slow, input bit gap, input bit neg);
        bit exp_lock;
        exp_lock = !neg || AMBIG;
        send_bit(1'b0, slow, 1'b0, neg);
        send_bit(1'b1, slow, 1'b0, neg);
        send_byte(8'hA5, slow, gap, neg);
        check("locked_before_sync", {31'd0, locked}, 32'd0);
        idle(1);
        check("locked_after_sync", {31'd0, locked}, {31'd0, exp_lock});
`ifdef BPSK_PHASE_AMBIG_EN
        check("phase_inv", {31'd0, phase_inv}, {31'd0, neg});
`endif
        if (exp_lock) exp_bytes.push_back(8'h3C);
        send_byte(8'h3C, slow, gap, neg);
        if (exp_lock) exp_bytes.push_back(8'hC3);
        send_byte(8'hC3, slow, gap, neg);
        idle(3);
        check("locked_after_frame", {31'd0, locked}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_out"},    {31'd0, bit_out},    32'd0);
        check({tag, "_bit_valid"},  {31'd0, bit_valid},  32'd0);
        check({tag, "_byte_out"},   {24'd0, byte_out},   32'd0);
        check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
        check({tag, "_locked"},     {31'd0, locked},     32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        sample_valid = 1'b0;
        resync       = 1'b0;
        sample_in    = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Slicer polarity and zero handling.
        send_level(0);
        send_level(1);
        send_level(2);

        // Nominal sync and frame.
        do_resync();
        send_stream(1'b0, 1'b0, 1'b0);

        // Sparse valid and an enable gap inside a symbol.
        do_resync();
        send_stream(1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-frame, three samples into a symbol.
        do_resync();
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("locked_pre_reset", {31'd0, locked}, 32'd1);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(12'sd500);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        tick();
        rst = 1'b0;
        tick();
        send_stream(1'b0, 1'b0, 1'b0);

        // resync after the first payload byte, then relock on the next A5.
        do_resync();
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        exp_bytes.push_back(8'h3C);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("locked_pre_resync", {31'd0, locked}, 32'd1);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("locked_post_resync", {31'd0, locked}, 32'd0);
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("locked_hunting", {31'd0, locked}, 32'd0);
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("locked_relock", {31'd0, locked}, 32'd1);
        exp_bytes.push_back(8'h3C);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        exp_bytes.push_back(8'hC3);
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("locked_relock_end", {31'd0, locked}, 32'd0);

        // Negated samples: locks only when phase ambiguity resolution is built in.
        do_resync();
        send_stream(1'b0, 1'b0, 1'b1);

        idle(4);
        check("bits_left", exp_bits.size(), 32'd0);
        check("bytes_left", exp_bytes.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bpsk_bit_slicer.md
Name: bpsk_bit_slicer

Overview:
- Sits directly downstream of the BPSK demodulator and consumes its per-sample product output `q`.
- Integrates and dumps `q` over one symbol period, slices each integral to a hard bit, and hunts for a sync word in the bit stream.
- Once locked, deserializes a fixed-length frame into bytes for the receive-side framer/UART path.

Parameters:
- SAMPLE_WIDTH, 12, width of signed input sample (matches demodulator DATA_WIDTH)
- SAMPLES_PER_BIT, 256, input samples per symbol (matches demodulator SAMPLE_NUMBER); must be ≥2
- SYNC_WORD, 8'hA5, 8-bit frame sync pattern, MSB first on air
- FRAME_BYTES, 4, payload bytes delivered per lock before returning to hunt; must be ≥1

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-high reset
- en, input, 1, block enable; low freezes all state
- sample_in, input, SAMPLE_WIDTH, signed demodulator product sample
- sample_valid, input, 1, sample_in is valid this cycle
- resync, input, 1, synchronous force back to HUNT
- bit_out, output, 1, sliced bit
- bit_valid, output, 1, one-cycle strobe for bit_out
- byte_out, output, 8, deserialized payload byte, MSB first
- byte_valid, output, 1, one-cycle strobe for byte_out
- locked, output, 1, high while state is LOCKED

Behaviour:
- Reset (async, rst=1):
  - acc, sample counter, shift register, bit/byte counters all = 0; state = HUNT.
  - All outputs 0.
- Accept rule: a sample is accepted when en && sample_valid. With en=0, nothing updates: counters and acc hold, and strobes are forced 0.
- Accumulator:
  - Signed, ACC_W = SAMPLE_WIDTH + clog2(SAMPLES_PER_BIT) bits; sample_in is sign-extended; no saturation is needed at this width.
  - The sample counter runs 0..SAMPLES_PER_BIT-1 and wraps.
  - On the accepted sample with count = SAMPLES_PER_BIT-1 (dump), sum = acc + sample:
    - Register bit_out = (sum > 0). Zero slices to 0.
    - Pulse bit_valid for the next cycle.
    - Clear acc to 0 and the counter to 0.
  - Latency: bit_valid is high exactly 1 cycle after the last sample of the symbol is accepted.
- FSM, advancing only on cycles where bit_valid=1:
  - HUNT:
    - shreg = {shreg[6:0], bit}.
    - If the new 8-bit shreg == SYNC_WORD → LOCKED, clear bit_cnt and byte_cnt.
    - At least 8 bits are needed since reset/resync before a match can fire; a 3-bit fill counter enforces this.
  - LOCKED:
    - Shift the bit into shreg; bit_cnt increments 0..7.
    - On the 8th bit, byte_out = new shreg and byte_valid pulses 1 cycle after that bit_valid; bit_cnt wraps; byte_cnt increments.
    - When byte_cnt reaches FRAME_BYTES → HUNT; the fill counter and shreg clear.
  - locked = (state == LOCKED), registered.
- resync:
  - Takes priority over the FSM in the same cycle: state = HUNT, fill/bit/byte counters and shreg clear.
  - Does not clear acc or the sample counter, so symbol timing is preserved.
  - A bit_valid in the same cycle is discarded by the FSM but still appears on bit_out/bit_valid.
- Sample phase: no timing recovery. The first accepted sample after reset is symbol phase 0.
- Bit and byte outputs hold their last value between strobes.

Optional Feature:
- Macro: BPSK_PHASE_AMBIG_EN, which resolves the 180° phase ambiguity.
- When defined:
  - HUNT also matches shreg == ~SYNC_WORD; that match sets an internal invert flag, cleared on the return to HUNT, reset or resync.
  - While invert=1, every bit entering shreg in LOCKED is inverted. bit_out itself is never inverted.
  - An extra output port, phase_inv (1 bit, reset 0), mirrors the invert flag.
- When undefined: only the true SYNC_WORD matches, and the phase_inv port does not exist.

Decomposition:
- Shared package bpsk_pkg:
  - Localparam-style constants SYNC_WORD_DEFAULT and FRAME_BYTES_DEFAULT.
  - An FSM state encoding (HUNT=1'b0, LOCKED=1'b1).
  - An ACC_W helper function (clog2).
- One natural sub-module: bpsk_integrate_dump, which holds the accumulator, sample counter, slicer and bit strobe. The top keeps the sync FSM and deserializer.

Test Plan (SAMPLES_PER_BIT=8, SYNC_WORD=8'hA5, FRAME_BYTES=2):
- Constant sample_in=+100 for 8 valid samples → bit_valid once, 1 cycle after the 8th sample, with bit_out=1. With −100 → bit_out=0. With samples summing to exactly 0 → bit_out=0.
- Bit stream 0,1 then A5, 3C, C3 (each bit as 8 samples of ±500) → locked rises after the A5 bits; byte_out=3C then C3 with byte_valid pulses; locked falls after the 2nd byte.
- Same stream with sample_valid toggling every other cycle and en low for 5 cycles mid-symbol → identical bits/bytes, only delayed; no strobes while en=0.
- Assert rst for 1 cycle mid-frame, 3 samples into a symbol → all outputs 0 immediately. A fresh sync then locks, with symbol phase restarted at 0.
- resync pulsed after byte 1 while locked → locked=0 the next cycle and no byte_valid for the remaining bits. The next A5 relocks.
- With BPSK_PHASE_AMBIG_EN: all samples negated (sync on air = 5A) → locks with phase_inv=1 and byte_out=3C, C3. Without the macro → never locks.
